// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction-timer game.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_ARMED,
    S_DONE,
    S_FALSE,
    S_LATE
  } state_e;

  localparam logic [2:0] COLOR_IDLE  = 3'b000;
  localparam logic [2:0] COLOR_RWAIT = 3'b100;
  localparam logic [2:0] COLOR_ARMED = 3'b010;
  localparam logic [2:0] COLOR_DONE  = 3'b001;
  localparam logic [2:0] COLOR_FALSE = 3'b110;
  localparam logic [2:0] COLOR_LATE  = 3'b101;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying the random wait extension.
module reaction_lfsr
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_fsm_multi.sv
// Multi-player reaction game: random wait, armed timing, result hold.
module reaction_fsm_multi
  import reaction_pkg::*;
#(
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned RWAIT_MIN  = 1000,
  parameter int unsigned SPAN_W     = 11,
  parameter int unsigned LATE_LIMIT = 1000,
  parameter int unsigned HOLD_TICKS = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] enter,
  output logic [2:0]           color_rgb,
  output logic                 time_clr,
  output logic                 time_en,
  output logic                 rs_en,
  output logic [2:0]           winner,
  output logic                 winner_valid,
  output logic                 false_start,
  output logic                 late,
  output logic [15:0]          react_ms
);

  localparam int unsigned WAIT_W = $clog2(RWAIT_MIN + (1 << SPAN_W)) + 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [15:0]          react_q, react_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [N_PLAYERS-1:0] enter_q;
  logic                 time_clr_q, time_clr_d;
  logic [2:0]           winner_q, winner_d;
  logic                 winner_valid_q, winner_valid_d;
  logic                 false_start_q, false_start_d;
  logic                 late_q, late_d;
  logic [15:0]          react_ms_q, react_ms_d;

  logic [15:0]          lfsr;
  logic [7:0]           press_pad;
  logic                 any_press;
  logic                 unused_lfsr;

  reaction_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  always_comb begin
    press_pad                = '0;
    press_pad[N_PLAYERS-1:0] = enter & ~enter_q;
    any_press                = |press_pad;
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    react_d        = react_q;
    hold_d         = hold_q;
    time_clr_d     = 1'b0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    false_start_d  = false_start_q;
    late_d         = late_q;
    react_ms_d     = react_ms_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_RWAIT;
          time_clr_d     = 1'b1;
          wait_d         = WAIT_W'(RWAIT_MIN) + WAIT_W'(lfsr[SPAN_W-1:0]);
          react_d        = '0;
          winner_valid_d = 1'b0;
          false_start_d  = 1'b0;
          late_d         = 1'b0;
          react_ms_d     = '0;
        end
      end
      S_RWAIT: begin
        if (any_press) begin
          state_d        = S_FALSE;
          hold_d         = '0;
          winner_d       = lowest_index(press_pad);
          winner_valid_d = 1'b1;
          false_start_d  = 1'b1;
        end else if (tick) begin
          wait_d = (wait_q == '0) ? '0 : wait_q - 1'b1;
          if (wait_q <= WAIT_W'(1)) begin
            state_d = S_ARMED;
            react_d = '0;
          end
        end
      end
      S_ARMED: begin
        // A press in the timeout cycle still counts as a valid reaction.
        if (any_press) begin
          state_d        = S_DONE;
          hold_d         = '0;
          winner_d       = lowest_index(press_pad);
          winner_valid_d = 1'b1;
          react_ms_d     = react_q;
        end else if (react_q == 16'(LATE_LIMIT)) begin
          state_d    = S_LATE;
          hold_d     = '0;
          late_d     = 1'b1;
          react_ms_d = 16'(LATE_LIMIT);
        end else if (tick && (react_q != 16'hFFFF)) begin
          react_d = react_q + 16'd1;
        end
      end
      S_DONE, S_FALSE, S_LATE: begin
        if (tick) begin
          if (hold_q >= HOLD_W'(HOLD_TICKS - 1)) begin
            state_d = S_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      react_q        <= '0;
      hold_q         <= '0;
      enter_q        <= '0;
      time_clr_q     <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      late_q         <= 1'b0;
      react_ms_q     <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      react_q        <= react_d;
      hold_q         <= hold_d;
      enter_q        <= enter;
      time_clr_q     <= time_clr_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      false_start_q  <= false_start_d;
      late_q         <= late_d;
      react_ms_q     <= react_ms_d;
    end
  end

  always_comb begin
    color_rgb = COLOR_IDLE;
    unique case (state_q)
      S_IDLE:  color_rgb = COLOR_IDLE;
      S_RWAIT: color_rgb = COLOR_RWAIT;
      S_ARMED: color_rgb = COLOR_ARMED;
      S_DONE:  color_rgb = COLOR_DONE;
      S_FALSE: color_rgb = COLOR_FALSE;
      S_LATE:  color_rgb = COLOR_LATE;
      default: color_rgb = COLOR_IDLE;
    endcase
  end

  assign time_en      = (state_q == S_ARMED);
  assign rs_en        = (state_q == S_RWAIT);
  assign time_clr     = time_clr_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign false_start  = false_start_q;
  assign late         = late_q;
  assign react_ms     = react_ms_q;

endmodule
